// File: rtl/text_banner_pixel.sv
// text_banner_pixel: overlays a fixed "LEVEL" label and a decimal readout of
// `value` onto a VGA scan. Glyph lookups go through memory_txt. Pixels leave
// the block two clocks after the h_cnt/v_cnt that produced them.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   value           binary number shown in the value row
//   blink_en        blinks the value row with a period of 2*BLINK_FRAMES frames
//   h_cnt, v_cnt    current scan position
//   pixel_out       RGB444 pixel, forced to 0 whenever valid is low
//   valid           pixel_out carries banner content
//
// memory_txt: 5x7 glyph ROM with a one-cycle registered read.
//   txt_addr        glyph code (0-9 digits, 14 E, 21 L, 31 V)
//   h_point/v_point dot column (0..4) / dot row (0..6) inside the glyph
//   pixel           ink colour for a lit dot, black otherwise

module text_banner_pixel #(
    parameter int unsigned N_DIGITS     = 3,
    parameter int unsigned VALUE_W      = 10,
    parameter int unsigned SCALE_SH     = 4,
    parameter int unsigned LBL_X        = 120,
    parameter int unsigned LBL_Y        = 28,
    parameter int unsigned VAL_X        = 240,
    parameter int unsigned VAL_Y        = 160,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value,
    input  logic               blink_en,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    output logic [11:0]        pixel_out,
    output logic               valid
);

    localparam int unsigned CELL_W  = 5 << SCALE_SH;
    localparam int unsigned CELL_H  = 7 << SCALE_SH;
    localparam int unsigned DIG_W   = 4 * N_DIGITS;
    // BCD register is always at least one digit wider than the display so the
    // overflow digits used for saturation exist for every parameter set.
    localparam int unsigned BCD_MIN = (VALUE_W * 3) / 10 + 2;
    localparam int unsigned BCD_N   = (BCD_MIN > N_DIGITS + 1) ? BCD_MIN : N_DIGITS + 1;
    localparam int unsigned BCD_W   = 4 * BCD_N;
    localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);
    localparam int unsigned FR_W    = $clog2(BLINK_FRAMES + 1);

    localparam logic [5:0] CODE_E = 6'd14;
    localparam logic [5:0] CODE_L = 6'd21;
    localparam logic [5:0] CODE_V = 6'd31;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    conv_state_t                  state;
    logic [VALUE_W-1:0]           cap;
    logic [VALUE_W-1:0]           shreg;
    logic [VALUE_W-1:0]           last_value;
    logic [CNT_W-1:0]             bit_cnt;
    logic [BCD_W-1:0]             bcd;
    logic [BCD_W-1:0]             bcd_adj;
    logic [N_DIGITS-1:0][3:0]     pending;
    logic                         pending_ok;
    logic [N_DIGITS-1:0][3:0]     shown;
    logic [FR_W-1:0]              frame_cnt;
    logic                         blink_phase;
    logic                         frame_start;

    logic                         lbl_in;
    logic                         val_in;
    logic [9:0]                   dx;
    logic [9:0]                   dy;
    logic [9:0]                   cell_off;
    logic [2:0]                   cell_idx;
    logic [2:0]                   n_sig;
    logic [2:0]                   dsel;
    logic                         s0_hit;
    logic [5:0]                   s0_addr;
    logic [2:0]                   s0_hp;
    logic [2:0]                   s0_vp;

    logic                         s1_hit;
    logic [5:0]                   s1_addr;
    logic [2:0]                   s1_hp;
    logic [2:0]                   s1_vp;
    logic [11:0]                  mem_pixel;

    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // Double-dabble adjust: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < BCD_N; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Binary-to-BCD conversion and frame-synchronous digit hand-off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap        <= '0;
            shreg      <= '0;
            last_value <= '0;
            bit_cnt    <= '0;
            bcd        <= '0;
            pending    <= '0;
            pending_ok <= 1'b0;
            shown      <= '0;
        end else begin
            if (frame_start && pending_ok) begin
                shown      <= pending;
                pending_ok <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (value != last_value) begin
                        cap     <= value;
                        shreg   <= value;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd   <= {bcd_adj[BCD_W-2:0], shreg[VALUE_W-1]};
                    shreg <= shreg << 1;
                    if (bit_cnt == CNT_W'(VALUE_W - 1))
                        state <= DONE;
                    else
                        bit_cnt <= bit_cnt + CNT_W'(1);
                end
                DONE: begin
                    // Any nonzero digit above the display width means overflow.
                    if (|bcd[BCD_W-1:DIG_W])
                        pending <= {N_DIGITS{4'd9}};
                    else
                        pending <= bcd[DIG_W-1:0];
                    last_value <= cap;
                    pending_ok <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Blink timing: counts frames while enabled, held at zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_en) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FR_W'(1);
            end
        end
    end

    // Number of significant digits; the readout is left-justified so the
    // suppressed leading zeros become blank cells at the right of the row.
    always_comb begin
        n_sig = 3'd1;
        for (int j = 1; j < N_DIGITS; j++) begin
            if (shown[j] != 4'd0)
                n_sig = 3'(j + 1);
        end
    end

    // Stage 0: window tests first, 10-bit offsets only for in-range positions.
    always_comb begin
        lbl_in = (32'(h_cnt) >= LBL_X) && (32'(h_cnt) < LBL_X + 5 * CELL_W) &&
                 (32'(v_cnt) >= LBL_Y) && (32'(v_cnt) < LBL_Y + CELL_H);
        val_in = (32'(h_cnt) >= VAL_X) && (32'(h_cnt) < VAL_X + N_DIGITS * CELL_W) &&
                 (32'(v_cnt) >= VAL_Y) && (32'(v_cnt) < VAL_Y + CELL_H);
    end

    always_comb begin
        s0_hit   = 1'b0;
        s0_addr  = '0;
        s0_hp    = '0;
        s0_vp    = '0;
        dx       = '0;
        dy       = '0;
        cell_idx = '0;
        cell_off = '0;
        dsel     = '0;
        if (lbl_in) begin
            dx = h_cnt - 10'(LBL_X);
            dy = v_cnt - 10'(LBL_Y);
            for (int i = 1; i < 5; i++) begin
                if (dx >= 10'(i * CELL_W)) begin
                    cell_idx = 3'(i);
                    cell_off = 10'(i * CELL_W);
                end
            end
            case (cell_idx)
                3'd1, 3'd3: s0_addr = CODE_E;
                3'd2:       s0_addr = CODE_V;
                default:    s0_addr = CODE_L;
            endcase
            s0_hp  = 3'((dx - cell_off) >> SCALE_SH);
            s0_vp  = 3'(dy >> SCALE_SH);
            s0_hit = 1'b1;
        end else if (val_in) begin
            dx = h_cnt - 10'(VAL_X);
            dy = v_cnt - 10'(VAL_Y);
            for (int i = 1; i < N_DIGITS; i++) begin
                if (dx >= 10'(i * CELL_W)) begin
                    cell_idx = 3'(i);
                    cell_off = 10'(i * CELL_W);
                end
            end
            // Leftmost cell carries the most significant displayed digit.
            dsel = n_sig - 3'd1 - cell_idx;
            for (int j = 0; j < N_DIGITS; j++) begin
                if (3'(j) == dsel)
                    s0_addr = {2'b00, shown[j]};
            end
            s0_hp  = 3'((dx - cell_off) >> SCALE_SH);
            s0_vp  = 3'(dy >> SCALE_SH);
            s0_hit = (cell_idx < n_sig) && !(blink_en && blink_phase);
        end
    end

    // Stage 1: glyph address registers feeding the ROM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_hit  <= 1'b0;
            s1_addr <= '0;
            s1_hp   <= '0;
            s1_vp   <= '0;
        end else begin
            s1_hit  <= s0_hit;
            s1_addr <= s0_addr;
            s1_hp   <= s0_hp;
            s1_vp   <= s0_vp;
        end
    end

    memory_txt u_memory_txt (
        .clk      (clk),
        .txt_addr (s1_addr),
        .h_point  (s1_hp),
        .v_point  (s1_vp),
        .pixel    (mem_pixel)
    );

    // Stage 2: hit flag aligned with the ROM's registered read.
    always_ff @(posedge clk) begin
        if (!rst_n)
            valid <= 1'b0;
        else
            valid <= s1_hit;
    end

    // ROM data has no reset; masking with valid keeps reset/idle output black.
    assign pixel_out = valid ? mem_pixel : 12'h000;

endmodule

module memory_txt (
    input  logic        clk,
    input  logic [5:0]  txt_addr,
    input  logic [2:0]  h_point,
    input  logic [2:0]  v_point,
    output logic [11:0] pixel
);

    localparam logic [11:0] INK = 12'hFFF;

    // glyph[6] is the top row; bit 4 of each row is the leftmost column.
    logic [6:0][4:0] glyph;
    logic [4:0]      row_bits;
    logic            dot;

    always_comb begin
        case (txt_addr)
            6'd0:  glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            6'd1:  glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            6'd2:  glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            6'd3:  glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            6'd4:  glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            6'd5:  glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            6'd6:  glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            6'd7:  glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            6'd8:  glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            6'd9:  glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            6'd14: glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
            6'd21: glyph = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
            6'd31: glyph = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
            default: glyph = '0;
        endcase
    end

    always_comb begin
        row_bits = '0;
        dot      = 1'b0;
        if ((v_point < 3'd7) && (h_point < 3'd5)) begin
            row_bits = glyph[3'd6 - v_point];
            dot      = row_bits[3'd4 - h_point];
        end
    end

    always_ff @(posedge clk) begin
        pixel <= dot ? INK : 12'h000;
    end

endmodule

// File: tb/tb_text_banner_pixel.sv
// Directed bench for text_banner_pixel; expected glyph dots are hand-decoded
// from the 5x7 font (row 0 = top, column 0 = leftmost dot).
module tb_text_banner_pixel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  value;
    logic        blink_en;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [11:0] pixel_out;
    logic        valid;

    int tests = 0;
    int fails = 0;

    text_banner_pixel #(.BLINK_FRAMES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .blink_en  (blink_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .pixel_out (pixel_out),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    // Present one scan position, return the outputs two clocks later.
    task automatic sample(input logic [9:0] h, input logic [9:0] v,
                          output logic vo, output logic [11:0] po);
        h_cnt = h;
        v_cnt = v;
        repeat (2) @(posedge clk);
        #1;
        vo = valid;
        po = pixel_out;
        h_cnt = 10'd5;
        v_cnt = 10'd5;
    endtask

    task automatic frame_start();
        h_cnt = 10'd0;
        v_cnt = 10'd0;
        @(posedge clk);
        #1;
        h_cnt = 10'd5;
        v_cnt = 10'd5;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        value    = 10'd0;
        blink_en = 1'b0;
        h_cnt    = 10'd120;
        v_cnt    = 10'd28;
        idle(3);
        tests++;
        if (valid !== 1'b0 || pixel_out !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b pixel=%h, expected 0/000", valid, pixel_out);
        end
        rst_n = 1'b1;
        idle(1);
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_flush: valid=%b, expected 0", valid);
        end
        idle(1);
        tests++;
        if (valid !== 1'b1 || pixel_out !== 12'hFFF) begin
            fails++;
            $display("FAIL reset_first_hit: valid=%b pixel=%h, expected 1/fff", valid, pixel_out);
        end
        h_cnt = 10'd5;
        v_cnt = 10'd5;
        idle(2);
    endtask

    task automatic test_label();
        logic [9:0]  hs [7] = '{10'd120, 10'd136, 10'd200, 10'd280, 10'd519, 10'd520, 10'd119};
        logic [9:0]  vs [7] = '{10'd28,  10'd28,  10'd28,  10'd28,  10'd139, 10'd28,  10'd28};
        logic        ev [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [11:0] ep [7] = '{12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
        logic        vo;
        logic [11:0] po;
        for (int i = 0; i < 7; i++) begin
            sample(hs[i], vs[i], vo, po);
            tests++;
            if (vo !== ev[i] || po !== ep[i]) begin
                fails++;
                $display("FAIL label[%0d] (%0d,%0d): valid=%b pixel=%h, expected %b/%h",
                         i, hs[i], vs[i], vo, po, ev[i], ep[i]);
            end
        end
    endtask

    task automatic test_value_zero();
        logic [9:0]  hs [6] = '{10'd240, 10'd256, 10'd319, 10'd320, 10'd239, 10'd240};
        logic [9:0]  vs [6] = '{10'd160, 10'd160, 10'd271, 10'd160, 10'd160, 10'd272};
        logic        ev [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [11:0] ep [6] = '{12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};
        logic        vo;
        logic [11:0] po;
        for (int i = 0; i < 6; i++) begin
            sample(hs[i], vs[i], vo, po);
            tests++;
            if (vo !== ev[i] || po !== ep[i]) begin
                fails++;
                $display("FAIL zero[%0d] (%0d,%0d): valid=%b pixel=%h, expected %b/%h",
                         i, hs[i], vs[i], vo, po, ev[i], ep[i]);
            end
        end
    endtask

    task automatic test_pipeline();
        logic        ev [3] = '{1'b0, 1'b1, 1'b0};
        logic [11:0] ep [3] = '{12'h000, 12'hFFF, 12'h000};
        h_cnt = 10'd120;
        v_cnt = 10'd28;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            h_cnt = 10'd5;
            v_cnt = 10'd5;
            tests++;
            if (valid !== ev[i] || pixel_out !== ep[i]) begin
                fails++;
                $display("FAIL pipeline[clk %0d]: valid=%b pixel=%h, expected %b/%h",
                         i + 1, valid, pixel_out, ev[i], ep[i]);
            end
        end
    endtask

    task automatic test_convert_123();
        logic [9:0]  hs [6] = '{10'd240, 10'd272, 10'd336, 10'd400, 10'd400, 10'd480};
        logic [9:0]  vs [6] = '{10'd160, 10'd160, 10'd160, 10'd160, 10'd176, 10'd160};
        logic        ev [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [11:0] ep [6] = '{12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
        logic        vo;
        logic [11:0] po;
        value = 10'd123;
        idle(20);
        sample(10'd320, 10'd160, vo, po);
        tests++;
        if (vo !== 1'b0) begin
            fails++;
            $display("FAIL convert_midframe: valid=%b, expected 0 before frame start", vo);
        end
        frame_start();
        for (int i = 0; i < 6; i++) begin
            sample(hs[i], vs[i], vo, po);
            tests++;
            if (vo !== ev[i] || po !== ep[i]) begin
                fails++;
                $display("FAIL show123[%0d] (%0d,%0d): valid=%b pixel=%h, expected %b/%h",
                         i, hs[i], vs[i], vo, po, ev[i], ep[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [9:0]  hs [6] = '{10'd240, 10'd256, 10'd400, 10'd416, 10'd400, 10'd480};
        logic [9:0]  vs [6] = '{10'd160, 10'd160, 10'd160, 10'd256, 10'd256, 10'd160};
        logic        ev [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [11:0] ep [6] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000};
        logic        vo;
        logic [11:0] po;
        value = 10'd1000;
        idle(20);
        frame_start();
        for (int i = 0; i < 6; i++) begin
            sample(hs[i], vs[i], vo, po);
            tests++;
            if (vo !== ev[i] || po !== ep[i]) begin
                fails++;
                $display("FAIL sat999[%0d] (%0d,%0d): valid=%b pixel=%h, expected %b/%h",
                         i, hs[i], vs[i], vo, po, ev[i], ep[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  hs [4] = '{10'd288, 10'd240, 10'd320, 10'd400};
        logic        ev [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [11:0] ep [4] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
        logic        vo;
        logic [11:0] po;
        value = 10'd45;
        idle(3);
        value = 10'd7;
        idle(12);
        frame_start();
        for (int i = 0; i < 4; i++) begin
            sample(hs[i], 10'd160, vo, po);
            tests++;
            if (vo !== ev[i] || po !== ep[i]) begin
                fails++;
                $display("FAIL show45[%0d] (%0d,160): valid=%b pixel=%h, expected %b/%h",
                         i, hs[i], vo, po, ev[i], ep[i]);
            end
        end
        idle(10);
        frame_start();
        sample(10'd240, 10'd160, vo, po);
        tests++;
        if (vo !== 1'b1 || po !== 12'hFFF) begin
            fails++;
            $display("FAIL show7_digit: valid=%b pixel=%h, expected 1/fff", vo, po);
        end
        sample(10'd320, 10'd160, vo, po);
        tests++;
        if (vo !== 1'b0) begin
            fails++;
            $display("FAIL show7_blank: valid=%b, expected 0", vo);
        end
    endtask

    task automatic test_blink();
        logic        vo;
        logic [11:0] po;
        logic        exp_vis;
        frame_start();
        blink_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            if (f > 0)
                frame_start();
            exp_vis = (f < 2) || (f >= 4);
            sample(10'd240, 10'd160, vo, po);
            tests++;
            if (vo !== exp_vis || po !== (exp_vis ? 12'hFFF : 12'h000)) begin
                fails++;
                $display("FAIL blink_value[frame %0d]: valid=%b pixel=%h, expected valid=%b",
                         f, vo, po, exp_vis);
            end
            sample(10'd120, 10'd28, vo, po);
            tests++;
            if (vo !== 1'b1 || po !== 12'hFFF) begin
                fails++;
                $display("FAIL blink_label[frame %0d]: valid=%b pixel=%h, expected 1/fff",
                         f, vo, po);
            end
        end
        blink_en = 1'b0;
        idle(2);
    endtask

    task automatic test_reset_mid_shift();
        logic [9:0]  hs [4] = '{10'd240, 10'd320, 10'd336, 10'd400};
        logic        ev [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [11:0] ep [4] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
        logic        vo;
        logic [11:0] po;
        h_cnt = 10'd120;
        v_cnt = 10'd28;
        value = 10'd500;
        idle(5);
        tests++;
        if (valid !== 1'b1 || pixel_out !== 12'hFFF) begin
            fails++;
            $display("FAIL pre_reset_label: valid=%b pixel=%h, expected 1/fff", valid, pixel_out);
        end
        rst_n = 1'b0;
        idle(1);
        tests++;
        if (valid !== 1'b0 || pixel_out !== 12'h000) begin
            fails++;
            $display("FAIL midshift_reset: valid=%b pixel=%h, expected 0/000", valid, pixel_out);
        end
        idle(1);
        rst_n = 1'b1;
        idle(1);
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL midshift_flush: valid=%b, expected 0", valid);
        end
        h_cnt = 10'd5;
        v_cnt = 10'd5;
        sample(10'd320, 10'd160, vo, po);
        tests++;
        if (vo !== 1'b0) begin
            fails++;
            $display("FAIL midshift_digits_cleared: valid=%b, expected 0", vo);
        end
        idle(15);
        frame_start();
        for (int i = 0; i < 4; i++) begin
            sample(hs[i], 10'd160, vo, po);
            tests++;
            if (vo !== ev[i] || po !== ep[i]) begin
                fails++;
                $display("FAIL show500[%0d] (%0d,160): valid=%b pixel=%h, expected %b/%h",
                         i, hs[i], vo, po, ev[i], ep[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_label();
        test_value_zero();
        test_pipeline();
        test_convert_123();
        test_saturate();
        test_back_to_back();
        test_blink();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_banner_pixel.md
TEXT_BANNER_PIXEL -- requirements
Module: text_banner_pixel

Interface
REQ-001 SHALL have parameter N_DIGITS, default 3: number of decimal digit cells in the value row (1..5).
REQ-002 SHALL have parameter VALUE_W, default 10: width of the binary value input.
REQ-003 SHALL have parameter SCALE_SH, default 4: glyph cell size is 2^SCALE_SH pixels per glyph dot.
REQ-004 SHALL have parameter LBL_X, default 120; LBL_Y, default 28: top-left of the 5-char "LEVEL" label row.
REQ-005 SHALL have parameter VAL_X, default 240; VAL_Y, default 160: top-left of the value row.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30: frames per blink half-period.
REQ-007 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-008 SHALL have ports: value in VALUE_W, binary number to display; blink_en in 1, enables blinking of the value row.
REQ-009 SHALL have ports: h_cnt in 10, v_cnt in 10, current VGA scan position.
REQ-010 SHALL have ports: pixel_out out 12, RGB444 pixel; valid out 1, pixel_out is banner content.
REQ-011 SHALL instantiate memory_txt (txt_addr 6 b, h_point 3 b, v_point 3 b, pixel 12 b, 1-cycle registered read); glyph is 5 dots wide x 7 dots high; codes 0-9 = digits, 14 = E, 21 = L, 31 = V.

Function
REQ-012 Cell width SHALL be 5<<SCALE_SH, height 7<<SCALE_SH; label occupies 5 adjacent cells, value row N_DIGITS adjacent cells.
REQ-013 Stage 0 (combinational): in-cell test, cell index, txt_addr, h_point=(h_cnt-cell_x)>>SCALE_SH, v_point=(v_cnt-row_y)>>SCALE_SH; all subtractions SHALL be done at 10 b after the in-range test, never on out-of-range counts.
REQ-014 Stage 1: txt_addr/h_point/v_point and hit flag registered; memory_txt addressed from these registers.
REQ-015 pixel_out and valid SHALL appear exactly 2 clk after the h_cnt/v_cnt they correspond to; valid=0 forces pixel_out=12'h000.
REQ-016 Conversion FSM states IDLE, SHIFT, DONE. IDLE: if value != last_value, capture value, clear BCD, go SHIFT.
REQ-017 SHIFT: per cycle, add 3 to each BCD nibble >=5, then shift left one bit from captured value; exactly VALUE_W cycles, then DONE.
REQ-018 DONE: BCD result written to pending_digits, last_value<=captured value, pending_ok<=1, back to IDLE (1 cycle).
REQ-019 value changing during SHIFT SHALL NOT abort; the new value is picked up in the IDLE following DONE.
REQ-020 Displayed digits SHALL update from pending_digits only at frame start (h_cnt==0 && v_cnt==0) when pending_ok=1, then pending_ok<=0; no mid-frame digit change.
REQ-021 Values >= 10^N_DIGITS SHALL display all nines (saturation), decided in DONE.
REQ-022 Leading-zero blanking: leading zero digit cells give valid=0; least-significant digit always shown (value 0 shows "0").
REQ-023 Frame counter increments at frame start; on reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
REQ-024 blink_en=1 and blink_phase=1 SHALL blank the value row (valid=0); label row never blinks; blink_en=0 forces blink_phase<=0 and counter<=0.
REQ-025 Label and value rows overlapping SHALL give label priority.

Reset
REQ-026 rst_n=0 at a clk edge SHALL set: FSM IDLE, last_value=0, BCD/pending/displayed digits=0, pending_ok=0, frame counter=0, blink_phase=0, pipeline hit flags=0, valid=0, pixel_out=0.
REQ-027 Reset mid-SHIFT SHALL discard the conversion; after release, a nonzero value restarts conversion in the next IDLE cycle.
REQ-028 For 2 clk after reset release valid SHALL remain 0 (pipeline flush).

Verification
REQ-029 Reset, value=0, scan full frame -> value row shows single "0" at x 240..319, y 160..271; label "LEVEL" at x 120..519, y 28..139; valid=0 elsewhere.
REQ-030 value=10'd123 mid-frame -> FSM done after 10+1 clk; digits stay "0" until next frame start, then "123" at x 240..479.
REQ-031 value=10'd1000, N_DIGITS=3 -> displays "999".
REQ-032 Drive h_cnt=120,v_cnt=28 for one clk -> pixel_out equals memory_txt(21,0,0) exactly 2 clk later; valid 1 clk wide aligned.
REQ-033 blink_en=1, BLINK_FRAMES=2 -> value row visible frames 0-1, blank frames 2-3, visible 4-5; label visible all frames.
REQ-034 Assert rst_n=0 on 5th SHIFT cycle of value=500 -> all outputs 0; after release conversion restarts and "500" appears at the following frame start.
